// File: rtl/md_pkg.sv
// Shared op codes and op classification for the multiply/divide unit.
// MD_MADD_EN enables the multiply-accumulate ops 7-10.
package md_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_MUL,
    CLS_DIV,
    CLS_MT
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    cls = CLS_NONE;
    case (op)
      OP_MULT, OP_MULTU: cls = CLS_MUL;
      OP_DIV, OP_DIVU:   cls = CLS_DIV;
      OP_MTHI, OP_MTLO:  cls = CLS_MT;
`ifdef MD_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: cls = CLS_MUL;
`endif
      default:           cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit multiply/divide result plus divide-by-zero flag.
// MD_MADD_EN adds the accumulate/subtract forms on top of {hi,lo}.
module md_calc
  import md_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dsr_s;
  logic [31:0] dsr_u;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic        b_zero;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes; -2^31 / -1 naturally wraps to 0x80000000.
  assign b_zero = (b == 32'd0);
  assign a_mag  = a[31] ? (32'd0 - a) : a;
  assign b_mag  = b[31] ? (32'd0 - b) : b;
  assign dsr_s  = b_zero ? 32'd1 : b_mag;
  assign dsr_u  = b_zero ? 32'd1 : b;
  assign q_mag  = a_mag / dsr_s;
  assign r_mag  = a_mag % dsr_s;
  assign q_s    = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s    = a[31] ? (32'd0 - r_mag) : r_mag;
  assign q_u    = a / dsr_u;
  assign r_u    = a % dsr_u;

  always_comb begin
    res      = {hi, lo};
    div_zero = 1'b0;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        div_zero = b_zero;
        if (!b_zero) res = {r_s, q_s};
      end
      OP_DIVU: begin
        div_zero = b_zero;
        if (!b_zero) res = {r_u, q_u};
      end
`ifdef MD_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s;
      OP_MADDU: res = {hi, lo} + prod_u;
      OP_MSUB:  res = {hi, lo} - prod_s;
      OP_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:  res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: latency down-counter, pending result, HI/LO.
// Result is computed at Start and held until the counter reaches its terminal count.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MD_Op,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  logic [CNT_W-1:0] cnt;
  logic [63:0]      pend;
  logic             pend_dz;
  logic [63:0]      calc_res;
  logic             calc_dz;
  op_class_e        cls;

  md_calc u_calc (
    .a        (A),
    .b        (B),
    .op       (MD_Op),
    .hi       (HI),
    .lo       (LO),
    .res      (calc_res),
    .div_zero (calc_dz)
  );

  assign cls  = op_class(MD_Op);
  assign Busy = (cnt != '0);

  // Any Start seen while the counter is running is dropped, MT writes included.
  always_ff @(posedge clk) begin
    if (reset) begin
      HI      <= 32'd0;
      LO      <= 32'd0;
      cnt     <= '0;
      pend    <= 64'd0;
      pend_dz <= 1'b0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1) && !pend_dz) begin
        HI <= pend[63:32];
        LO <= pend[31:0];
      end
    end else if (Start) begin
      case (cls)
        CLS_MUL: begin
          pend    <= calc_res;
          pend_dz <= 1'b0;
          cnt     <= CNT_W'(MULT_LAT);
        end
        CLS_DIV: begin
          pend    <= calc_res;
          pend_dz <= calc_dz;
          cnt     <= CNT_W'(DIV_LAT);
        end
        CLS_MT: begin
          if (MD_Op == OP_MTHI) HI <= A;
          else                  LO <= A;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus random ops against an arithmetic model.
// MD_MADD_EN selects whether ops 7-10 are expected to accumulate or be ignored.
module tb_md_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MD_Op;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  always #5 clk = ~clk;

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MD_Op (MD_Op),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lat(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd2) return MULT_LAT;
    if (op >= 4'd3 && op <= 4'd4) return DIV_LAT;
`ifdef MD_MADD_EN
    if (op >= 4'd7 && op <= 4'd10) return MULT_LAT;
`endif
    return 0;
  endfunction

  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] hilo);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return ua * ub;
      4'd3: begin
        if (b == 32'd0) return hilo;
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return hilo;
        return {32'(ua % ub), 32'(ua / ub)};
      end
`ifdef MD_MADD_EN
      4'd7:  return hilo + 64'(sa * sb);
      4'd8:  return hilo + ua * ub;
      4'd9:  return hilo - 64'(sa * sb);
      4'd10: return hilo - ua * ub;
`endif
      default: return hilo;
    endcase
  endfunction

  // intr_kind: 0 none, 1 MTLO strobe in busy cycle intr_cyc, 2 reset in busy cycle intr_cyc
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int intr_cyc, input int intr_kind);
    logic [63:0] old_v;
    logic [63:0] exp_v;
    int          lat;
    old_v = {hi_m, lo_m};
    exp_v = ref_result(op, a, b, old_v);
    lat   = ref_lat(op);
    MD_Op = op; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; MD_Op = 4'd0;
    if (lat == 0) begin
      if (op == 4'd5) hi_m = a;
      else if (op == 4'd6) lo_m = a;
      check_val("nolat_busy", {63'd0, Busy}, 64'd0);
      check_val("nolat_hilo", {HI, LO}, {hi_m, lo_m});
      return;
    end
    for (int i = 1; i <= lat; i++) begin
      check_val("busy_hi", {63'd0, Busy}, 64'd1);
      check_val("hold_hilo", {HI, LO}, old_v);
      if (i == intr_cyc && intr_kind == 1) begin
        MD_Op = 4'd6; A = 32'hDEAD_BEEF; Start = 1'b1;
      end
      if (i == intr_cyc && intr_kind == 2) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        check_val("abort_busy", {63'd0, Busy}, 64'd0);
        check_val("abort_hilo", {HI, LO}, 64'd0);
        for (int j = 0; j < lat; j++) begin
          @(negedge clk);
          check_val("abort_nocommit", {Busy, HI, LO}, 65'd0);
        end
        return;
      end
      @(negedge clk);
      Start = 1'b0; MD_Op = 4'd0;
    end
    {hi_m, lo_m} = exp_v;
    check_val("done_busy", {63'd0, Busy}, 64'd0);
    check_val("done_hilo", {HI, LO}, {hi_m, lo_m});
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b1; Start = 1'b0; A = 32'd0; B = 32'd0; MD_Op = 4'd0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", {63'd0, Busy}, 64'd0);
    check_val("rst_hilo", {HI, LO}, 64'd0);
    reset = 1'b0;

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0, 0);
    check_val("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check_val("multu_const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    check_val("div_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd4, 32'd7, 32'd0, 0, 0);
    check_val("divu_zero", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check_val("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);
    run_op(4'd5, 32'h1234, 32'd0, 0, 0);
    check_val("mthi_const", {32'd0, HI}, 64'h1234);
    run_op(4'd1, 32'd100, 32'd7, 2, 1);
    check_val("mtlo_ignored", {32'd0, LO}, 64'd700);
    run_op(4'd0, 32'h55, 32'h66, 0, 0);
    run_op(4'd11, 32'h55, 32'h66, 0, 0);
    run_op(4'd15, 32'h55, 32'h66, 0, 0);

    run_op(4'd5, 32'd0, 32'd0, 0, 0);
    run_op(4'd6, 32'd10, 32'd0, 0, 0);
    run_op(4'd7, 32'd2, 32'd3, 0, 0);
`ifdef MD_MADD_EN
    check_val("madd_const", {HI, LO}, 64'd16);
`else
    check_val("madd_ignored", {HI, LO}, 64'd10);
`endif

    run_op(4'd3, 32'd1000, 32'd3, 4, 2);
    check_val("post_abort", {HI, LO}, 64'd0);

    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 12));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      run_op(op, ra, rb, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
